// File: rtl/mem_arbiter.sv
// Three-way arbiter sharing one single-port memory between instruction fetch (I),
// data load/store (D) and a host port (H), with a fixed access latency.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int LATENCY = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic [DW-1:0] i_rdata_o,
  output logic          i_ack_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ack_o,
  input  logic          h_req_i,
  input  logic          h_we_i,
  input  logic [AW-1:0] h_addr_i,
  input  logic [DW-1:0] h_wdata_i,
  output logic [DW-1:0] h_rdata_o,
  output logic          h_ack_o,
  output logic          m_en_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i,
  output logic [1:0]    grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_I    = 2'd1;
  localparam logic [1:0] G_D    = 2'd2;
  localparam logic [1:0] G_H    = 2'd3;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_is_d_q, last_is_d_d;  // 0: I was served last, 1: D
  logic [3:0]    cnt_q, cnt_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;
  logic [2:0]    ack_q, ack_d;  // {H, D, I}

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= G_NONE;
      last_is_d_q <= 1'b0;
      cnt_q       <= '0;
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      h_rdata_q   <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_is_d_q <= last_is_d_d;
      cnt_q       <= cnt_d;
      m_en_q      <= m_en_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      h_rdata_q   <= h_rdata_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_is_d_d = last_is_d_q;
    cnt_d       = cnt_q;
    m_en_d      = m_en_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    h_rdata_d   = h_rdata_q;
    ack_d       = '0;

    unique case (state_q)
      IDLE: begin
        if (h_req_i || d_req_i || i_req_i) begin
          // H always wins; on an I/D tie the one not served last goes first
          if (h_req_i) begin
            grant_d   = G_H;
            m_we_d    = h_we_i;
            m_addr_d  = h_addr_i;
            m_wdata_d = h_wdata_i;
          end else if (d_req_i && (!i_req_i || !last_is_d_q)) begin
            grant_d   = G_D;
            m_we_d    = d_we_i;
            m_addr_d  = d_addr_i;
            m_wdata_d = d_wdata_i;
          end else begin
            grant_d   = G_I;
            m_we_d    = 1'b0;
            m_addr_d  = i_addr_i;
            m_wdata_d = '0;
          end
          m_en_d  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          unique case (grant_q)
            G_I: begin
              i_rdata_d = m_rdata_i;
              ack_d     = 3'b001;
            end
            G_D: begin
              if (!m_we_q) d_rdata_d = m_rdata_i;
              ack_d = 3'b010;
            end
            G_H: begin
              if (!m_we_q) h_rdata_d = m_rdata_i;
              ack_d = 3'b100;
            end
            default: ack_d = 3'b000;
          endcase
          m_en_d  = 1'b0;
          m_we_d  = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (grant_q == G_I) last_is_d_d = 1'b0;
        if (grant_q == G_D) last_is_d_d = 1'b1;
        grant_d = G_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;
  assign h_rdata_o = h_rdata_q;
  assign i_ack_o   = ack_q[0];
  assign d_ack_o   = ack_q[1];
  assign h_ack_o   = ack_q[2];
  assign m_en_o    = m_en_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random request mixes, checked
// against a transaction-level model of arbitration order, memory contents and RDATA.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req, d_req, d_we, h_req, h_we;
  logic [15:0] i_addr, d_addr, d_wdata, h_addr, h_wdata;
  logic [15:0] i_rdata, d_rdata, h_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ack, d_ack, h_ack, m_en, m_we;
  logic [1:0]  grant;

  // second instance with LATENCY = 1, instruction port only
  logic        i2_req;
  logic [15:0] i2_addr, i2_rdata, m2_addr, m2_wdata, m2_rdata, d2_rdata, h2_rdata;
  logic        i2_ack, d2_ack, h2_ack, m2_en, m2_we;
  logic [1:0]  grant2;
  logic        zero1;
  logic [15:0] zero16;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a[8:0] == 9'h010) return 16'h1234;
    return {a[7:0], ~a[7:0]};
  endfunction

  // memory device: initial contents from init_val, overlaid by writes
  logic [15:0] ram [0:511];
  logic        written [0:511];
  always @(posedge clk)
    if (m_en && m_we) begin
      ram[m_addr[8:0]]     <= m_wdata;
      written[m_addr[8:0]] <= 1'b1;
    end
  assign m_rdata  = (written[m_addr[8:0]] === 1'b1) ? ram[m_addr[8:0]] : init_val(m_addr);
  assign m2_rdata = init_val(m2_addr);

  mem_arbiter #(.AW(16), .DW(16), .LATENCY(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_ack_o(i_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdata_i(h_wdata),
    .h_rdata_o(h_rdata), .h_ack_o(h_ack),
    .m_en_o(m_en), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata), .grant_o(grant)
  );

  mem_arbiter #(.AW(16), .DW(16), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i2_req), .i_addr_i(i2_addr), .i_rdata_o(i2_rdata), .i_ack_o(i2_ack),
    .d_req_i(zero1), .d_we_i(zero1), .d_addr_i(zero16), .d_wdata_i(zero16),
    .d_rdata_o(d2_rdata), .d_ack_o(d2_ack),
    .h_req_i(zero1), .h_we_i(zero1), .h_addr_i(zero16), .h_wdata_i(zero16),
    .h_rdata_o(h2_rdata), .h_ack_o(h2_ack),
    .m_en_o(m2_en), .m_we_o(m2_we), .m_addr_o(m2_addr), .m_wdata_o(m2_wdata),
    .m_rdata_i(m2_rdata), .grant_o(grant2)
  );

  // reference model state
  logic [15:0] mem_m [0:511];
  logic [15:0] rd_m [1:3];
  logic        last_m;  // 1 when D was the last I/D requester served

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Raise the given requests at a negedge with the DUT idle and serve them all.
  task automatic run_round(input logic ri, input logic rd, input logic rh);
    logic pi, pd, ph, first, got, ewe;
    logic [15:0] ea, ewd;
    logic [31:0] obs_rd;
    int win, kbeg;
    pi = ri; pd = rd; ph = rh; first = 1'b1;
    i_req = ri; d_req = rd; h_req = rh;
    while (pi || pd || ph) begin
      if (ph) win = 3;
      else if (pi && pd) win = last_m ? 1 : 2;
      else if (pd) win = 2;
      else win = 1;
      case (win)
        1: begin ea = i_addr; ewe = 1'b0; ewd = 16'h0; end
        2: begin ea = d_addr; ewe = d_we; ewd = d_wdata; end
        default: begin ea = h_addr; ewe = h_we; ewd = h_wdata; end
      endcase
      kbeg = first ? 1 : 2;
      got = 1'b0;
      for (int k = 1; k <= LAT + 4 && !got; k++) begin
        @(negedge clk);
        if (k == kbeg) begin
          chk("grant", 32'(grant), 32'(win));
          chk("m_addr", 32'(m_addr), 32'(ea));
          chk("m_we", 32'(m_we), 32'(ewe));
          if (ewe) chk("m_wdata", 32'(m_wdata), 32'(ewd));
        end
        if (k >= kbeg && k < kbeg + LAT) chk("m_en_busy", 32'(m_en), 32'd1);
        if (i_ack || d_ack || h_ack) begin
          got = 1'b1;
          chk("ack_latency", 32'(k), 32'(kbeg + LAT));
          chk("ack_owner", 32'({h_ack, d_ack, i_ack}), 32'(1) << (win - 1));
          chk("m_en_resp", 32'(m_en), 32'd0);
          if (ewe) mem_m[ea[8:0]] = ewd;
          else rd_m[win] = mem_m[ea[8:0]];
          case (win)
            1: obs_rd = 32'(i_rdata);
            2: obs_rd = 32'(d_rdata);
            default: obs_rd = 32'(h_rdata);
          endcase
          chk("rdata", obs_rd, 32'(rd_m[win]));
          $display("txn owner=%0d we=%0b addr=0x%04h wdata=0x%04h rdata=0x%04h", win, ewe, ea, ewd, obs_rd[15:0]);
          case (win)
            1: begin i_req = 1'b0; pi = 1'b0; last_m = 1'b0; end
            2: begin d_req = 1'b0; pd = 1'b0; last_m = 1'b1; end
            default: begin h_req = 1'b0; ph = 1'b0; end
          endcase
        end
      end
      chk("ack_seen", 32'(got), 32'd1);
      if (!got) begin
        i_req = 1'b0; d_req = 1'b0; h_req = 1'b0;
        pi = 1'b0; pd = 1'b0; ph = 1'b0;
      end
      first = 1'b0;
    end
    @(negedge clk);
    chk("grant_idle", 32'(grant), 32'd0);
  endtask

  initial begin
    logic got;
    for (int a = 0; a < 512; a++) mem_m[a] = init_val(16'(a));
    rd_m[1] = 16'h0; rd_m[2] = 16'h0; rd_m[3] = 16'h0;
    last_m = 1'b0;
    zero1 = 1'b0; zero16 = 16'h0;
    i_req = 0; d_req = 0; h_req = 0; d_we = 0; h_we = 0; i2_req = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; h_addr = 0; h_wdata = 0; i2_addr = 0;
    rst = 1'b1;
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wdata", 32'(m_wdata), 32'd0);
    chk("rst_acks", 32'({h_ack, d_ack, i_ack}), 32'd0);
    chk("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
    chk("rst_h_rdata", 32'(h_rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single I read, then a D write
    i_addr = 16'h0010;
    run_round(1'b1, 1'b0, 1'b0);
    d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    run_round(1'b0, 1'b1, 1'b0);

    // fresh reset: I/D tie goes to D first, then strict alternation
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    last_m = 1'b0; rd_m[1] = 16'h0; rd_m[2] = 16'h0; rd_m[3] = 16'h0;
    @(negedge clk);
    d_we = 1'b0; d_addr = 16'h0100; i_addr = 16'h0020;
    run_round(1'b1, 1'b1, 1'b0);
    i_addr = 16'h0021; d_addr = 16'h0022;
    run_round(1'b1, 1'b1, 1'b0);

    // H beats both; I/D order continues from before
    h_we = 1'b1; h_addr = 16'h0030; h_wdata = 16'hCAFE;
    run_round(1'b1, 1'b1, 1'b1);
    h_we = 1'b0; h_addr = 16'h0030;
    run_round(1'b1, 1'b1, 1'b1);

    // random request mixes
    for (int r = 0; r < 25; r++) begin
      int mask;
      mask = $urandom_range(1, 7);
      i_addr  = 16'($urandom_range(0, 511));
      d_addr  = 16'($urandom_range(0, 511));
      h_addr  = 16'($urandom_range(0, 511));
      d_we    = 1'($urandom_range(0, 1));
      h_we    = 1'($urandom_range(0, 1));
      d_wdata = 16'($urandom);
      h_wdata = 16'($urandom);
      run_round(mask[0], mask[1], mask[2]);
    end

    // reset in the middle of a D read
    d_we = 1'b0; d_addr = 16'h0055;
    run_round(1'b0, 1'b1, 1'b0);
    d_addr = 16'h0056; d_req = 1'b1;
    @(negedge clk);
    chk("busy_before_rst", 32'(m_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_m_en", 32'(m_en), 32'd0);
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_d_rdata", 32'(d_rdata), 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_m = 1'b0; rd_m[1] = 16'h0; rd_m[2] = 16'h0; rd_m[3] = 16'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_ack_after_rst", 32'({h_ack, d_ack, i_ack}), 32'd0);
    end
    i_addr = 16'h0077;
    run_round(1'b1, 1'b0, 1'b0);

    // LATENCY = 1: back-to-back I reads at 0x0000 then 0x0001
    i2_addr = 16'h0000; i2_req = 1'b1;
    for (int j = 0; j < 2; j++) begin
      got = 1'b0;
      for (int k = 1; k <= 6 && !got; k++) begin
        @(negedge clk);
        if (i2_ack) begin
          got = 1'b1;
          chk("l1_latency", 32'(k), (j == 0) ? 32'd2 : 32'd3);
          chk("l1_rdata", 32'(i2_rdata), 32'(init_val(16'(j))));
          $display("txn l1 owner=1 addr=0x%04h rdata=0x%04h", 16'(j), i2_rdata);
          if (j == 0) i2_addr = 16'h0001;
          else i2_req = 1'b0;
        end
      end
      chk("l1_ack_seen", 32'(got), 32'd1);
    end
    i2_req = 1'b0;
    @(negedge clk);
    chk("l1_grant_idle", 32'(grant2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
